// File: rtl/completion_tracker.sv
// completion_tracker: counts processed elements for an operation whose
// target depends on the mode latched at start, and raises a sticky
// finished flag once the target is reached. Sticky err flags starts that
// arrive while an operation is still outstanding.
module completion_tracker #(
    parameter int unsigned N    = 6,
    parameter int unsigned K    = 2,
    parameter int unsigned TGT0 = 1,
    parameter int unsigned TGT1 = 20,
    parameter int unsigned TGT2 = 8,
    parameter int unsigned TGT3 = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [K-1:0] op_type,
    input  logic         step,
    input  logic         ack,
    input  logic         abort,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         finished,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] target_q, target_d;
    logic         busy_q, busy_d;
    logic         finished_q, finished_d;
    logic         err_q, err_d;

    logic [N-1:0] tgt_sel;
    logic [N-1:0] count_inc;
    logic         violation;
    int unsigned  op_idx;

    // Map the requested mode to its element target; unlisted modes use TGT0.
    always_comb begin
        op_idx = 32'(op_type);
        case (op_idx)
            1:       tgt_sel = N'(TGT1);
            2:       tgt_sel = N'(TGT2);
            3:       tgt_sel = N'(TGT3);
            default: tgt_sel = N'(TGT0);
        endcase
    end

    // Next-state logic; abort dominates everything except the err set path.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        target_d  = target_q;
        count_inc = count_q + 1'b1;

        // A start is a violation only when it cannot be accepted.
        violation = start && ((state_q == RUN) || ((state_q == DONE) && !ack));
        if (violation) begin
            err_d = 1'b1;
        end else if (ack || abort) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        target_d = tgt_sel;
                        count_d  = '0;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    // Zero target finishes immediately; steps cannot push
                    // count past the target because DONE is entered on match.
                    if (target_q == '0) begin
                        state_d = DONE;
                    end else if (step) begin
                        count_d = count_inc;
                        if (count_inc == target_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (ack) begin
                        if (start) begin
                            target_d = tgt_sel;
                            count_d  = '0;
                            state_d  = RUN;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end

        busy_d     = (state_d == RUN);
        finished_d = (state_d == DONE);
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            target_q   <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            target_q   <= target_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            err_q      <= err_d;
        end
    end

    assign count    = count_q;
    assign busy     = busy_q;
    assign finished = finished_q;
    assign err      = err_q;

endmodule

// File: tb/tb_completion_tracker.sv
// Directed bench for completion_tracker with N=6, K=2, targets 1/20/8/0.
module tb_completion_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op_type = 2'd0;
    logic       step = 1'b0;
    logic       ack = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] count;
    logic       busy;
    logic       finished;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    completion_tracker #(
        .N(6), .K(2), .TGT0(1), .TGT1(20), .TGT2(8), .TGT3(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op_type(op_type),
        .step(step), .ack(ack), .abort(abort),
        .count(count), .busy(busy), .finished(finished), .err(err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs set before this apply at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] op);
        start = 1'b1; op_type = op;
        tick();
        start = 1'b0;
    endtask

    task automatic do_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step = 1'b1;
            tick();
        end
        step = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL reset_finished got %b exp 0", finished); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_op0();
        do_start(2'd0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL op0_busy got %b exp 1", busy); end
        do_steps(1);
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL op0_finished got %b exp 1", finished); end
        vectors++; if (count !== 6'd1) begin miscompares++; $display("FAIL op0_count got %0d exp 1", count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL op0_busy_done got %b exp 0", busy); end
        do_ack();
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL op0_ack got %b exp 0", finished); end
    endtask

    task automatic test_op1_gaps();
        do_start(2'd1);
        for (int i = 1; i <= 20; i++) begin
            do_steps(1);
            if (i == 19) begin
                vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL op1_fin19 got %b exp 0", finished); end
                vectors++; if (count !== 6'd19) begin miscompares++; $display("FAIL op1_cnt19 got %0d exp 19", count); end
            end
            if (i == 20) begin
                vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL op1_fin20 got %b exp 1", finished); end
                vectors++; if (count !== 6'd20) begin miscompares++; $display("FAIL op1_cnt20 got %0d exp 20", count); end
            end
            repeat (i % 3) tick();
        end
        for (int j = 0; j < 5; j++) begin
            tick();
            vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL op1_hold%0d got %b exp 1", j, finished); end
        end
        vectors++; if (count !== 6'd20) begin miscompares++; $display("FAIL op1_hold_cnt got %0d exp 20", count); end
        do_ack();
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL op1_ack got %b exp 0", finished); end
    endtask

    task automatic test_err_in_run();
        do_start(2'd1);
        do_steps(5);
        do_start(2'd2);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_set got %b exp 1", err); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL err_busy got %b exp 1", busy); end
        vectors++; if (count !== 6'd5) begin miscompares++; $display("FAIL err_cnt got %0d exp 5", count); end
        do_steps(15);
        vectors++; if (count !== 6'd20) begin miscompares++; $display("FAIL err_cnt20 got %0d exp 20", count); end
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL err_fin got %b exp 1", finished); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b exp 1", err); end
        do_ack();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b exp 0", err); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL err_fin_clear got %b exp 0", finished); end
    endtask

    task automatic test_back_to_back();
        do_start(2'd0);
        do_steps(1);
        start = 1'b1; op_type = 2'd2; ack = 1'b1;
        tick();
        start = 1'b0; ack = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %b exp 1", busy); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL b2b_fin got %b exp 0", finished); end
        vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL b2b_cnt got %0d exp 0", count); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL b2b_err got %b exp 0", err); end
        do_steps(7);
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL b2b_fin7 got %b exp 0", finished); end
        do_steps(1);
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL b2b_fin8 got %b exp 1", finished); end
        vectors++; if (count !== 6'd8) begin miscompares++; $display("FAIL b2b_cnt8 got %0d exp 8", count); end
        do_ack();
    endtask

    task automatic test_zero_target();
        do_start(2'd3);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL zero_busy got %b exp 1", busy); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL zero_fin0 got %b exp 0", finished); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy2 got %b exp 0", busy); end
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL zero_fin got %b exp 1", finished); end
        vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL zero_cnt got %0d exp 0", count); end
        do_ack();
    endtask

    task automatic test_async_reset();
        do_start(2'd1);
        do_steps(7);
        do_start(2'd0);
        vectors++; if (count !== 6'd7) begin miscompares++; $display("FAIL ar_pre_cnt got %0d exp 7", count); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ar_pre_err got %b exp 1", err); end
        #2 rst = 1'b0;
        #1;
        vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL ar_cnt got %0d exp 0", count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ar_busy got %b exp 0", busy); end
        vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL ar_fin got %b exp 0", finished); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ar_err got %b exp 0", err); end
        rst = 1'b1;
        tick();
        do_steps(1);
        vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL ar_step_cnt got %0d exp 0", count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ar_step_busy got %b exp 0", busy); end
    endtask

    task automatic test_abort();
        do_start(2'd1);
        do_steps(3);
        vectors++; if (count !== 6'd3) begin miscompares++; $display("FAIL ab_pre_cnt got %0d exp 3", count); end
        abort = 1'b1; step = 1'b1;
        tick();
        abort = 1'b0; step = 1'b0;
        vectors++; if (count !== 6'd0) begin miscompares++; $display("FAIL ab_cnt got %0d exp 0", count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ab_busy got %b exp 0", busy); end
        for (int j = 0; j < 3; j++) begin
            vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL ab_fin%0d got %b exp 0", j, finished); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_op0();
        test_op1_gaps();
        test_err_in_run();
        test_back_to_back();
        test_zero_target();
        test_async_reset();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
